// File: rtl/instr_issue_sequencer.sv
// Round-robin merge of two instruction sources into a FIFO, issued one at a time
// to the processor with an arm (sig low) / execute (sig high) handshake and a timeout.
module instr_issue_sequencer #(
  parameter int INSTR_W = 34,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [INSTR_W-1:0]       req0_instr,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [INSTR_W-1:0]       req1_instr,
  output logic                     req1_ready,
  output logic [INSTR_W-1:0]       proc_instr,
  output logic                     proc_instr_sig,
  input  logic                     proc_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              issued_cnt,
  output logic                     timeout_err,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    EXEC   = 2'd2,
    RETIRE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               rr_q, rr_d;
  logic [INSTR_W-1:0] proc_instr_q, proc_instr_d;
  logic               sig_q, sig_d;
  logic               busy_q, busy_d;
  logic [15:0]        issued_q, issued_d;
  logic               timeout_q, timeout_d;
  logic [TW-1:0]      timer_q, timer_d;

  logic               full, gnt0, gnt1, push, pop;
  logic [INSTR_W-1:0] push_data;

  // Handshake: a source transfers on a rising edge where valid and ready are both 1.
  // ready is combinational, never depends on a same-cycle pop, and at most one is high.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    gnt0      = !full && req0_valid && (!req1_valid || !rr_q);
    gnt1      = !full && req1_valid && (!req0_valid ||  rr_q);
    push      = gnt0 || gnt1;
    push_data = gnt0 ? req0_instr : req1_instr;
    pop       = (state_q == IDLE) && (count_q != '0);

    // rr_q names the source that wins a tie; it moves only on a transfer
    rr_d = rr_q;
    if (gnt0)      rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    issued_d     = issued_q;
    timeout_d    = timeout_q;
    proc_instr_d = proc_instr_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          proc_instr_d = mem_q[rd_ptr_q];
          state_d      = ARM;
        end
      end
      ARM: begin
        timer_d = '0;
        state_d = EXEC;
      end
      EXEC: begin
        // done takes priority over a timeout landing on the same cycle
        if (proc_done) begin
          issued_d = issued_q + 16'd1;
          state_d  = RETIRE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = RETIRE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RETIRE: begin
        timer_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sig_d  = (state_d == EXEC);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_q         <= 1'b0;
      proc_instr_q <= '0;
      sig_q        <= 1'b0;
      busy_q       <= 1'b0;
      issued_q     <= '0;
      timeout_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      proc_instr_q <= proc_instr_d;
      sig_q        <= sig_d;
      busy_q       <= busy_d;
      issued_q     <= issued_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign req0_ready     = gnt0;
  assign req1_ready     = gnt1;
  assign proc_instr     = proc_instr_q;
  assign proc_instr_sig = sig_q;
  assign busy           = busy_q;
  assign fifo_count     = count_q;
  assign issued_cnt     = issued_q;
  assign timeout_err    = timeout_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Directed bench for instr_issue_sequencer with a small processor model that
// pulses done a programmable number of execute cycles after sig rises.
module tb_instr_issue_sequencer;

  localparam int IW = 34;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [IW-1:0] req0_instr, req1_instr;
  logic          req0_ready, req1_ready;
  logic [IW-1:0] proc_instr;
  logic          proc_instr_sig;
  logic          proc_done;
  logic          busy;
  logic [2:0]    fifo_count;
  logic [15:0]   issued_cnt;
  logic          timeout_err;
  logic [1:0]    state_dbg;

  instr_issue_sequencer #(.INSTR_W(IW), .DEPTH(4), .TIMEOUT(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(req1_ready),
    .proc_instr(proc_instr), .proc_instr_sig(proc_instr_sig), .proc_done(proc_done),
    .busy(busy), .fifo_count(fifo_count), .issued_cnt(issued_cnt),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [IW-1:0] exp_q[$];

  int done_delay = 0;
  logic force_done = 1'b0;
  int k = 0;
  int last_len = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] a_val(input int i);
    return 34'h1_0000_0A00 + IW'(i);
  endfunction

  function automatic logic [IW-1:0] b_val(input int i);
    return 34'h2_0000_0B00 + IW'(i);
  endfunction

  // processor model plus issue-order scoreboard
  always @(negedge clk) begin
    if (!proc_instr_sig) begin
      if (k != 0) last_len = k;
      k = 0;
      proc_done = force_done;
    end else begin
      k++;
      if (k == 1) begin
        logic has;
        has = (exp_q.size() != 0);
        check("issue_expected", has, 1);
        if (has) check("issue_order", proc_instr, exp_q.pop_front());
      end
      proc_done = force_done || (done_delay != 0 && k == done_delay);
    end
  end

  initial begin
    int i0, i1, n, acc;
    logic r0, r1;
    logic [6:0] seq;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_instr = '0;   req1_instr = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_sig", proc_instr_sig, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_instr", proc_instr, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;

    // both sources valid continuously: grants alternate starting with source 0
    done_delay = 2;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(a_val(i));
      exp_q.push_back(b_val(i));
    end
    i0 = 0; i1 = 0; n = 0;
    while ((i0 < 6 || i1 < 6) && n < 1000) begin
      @(negedge clk);
      req0_valid = (i0 < 6); req0_instr = a_val(i0);
      req1_valid = (i1 < 6); req1_instr = b_val(i1);
      #1;
      r0 = req0_ready; r1 = req1_ready;
      if (r0 && r1) check("alt_one_grant", {r0, r1}, 2'b01);
      @(posedge clk);
      if (r0) i0++;
      if (r1) i1++;
      n++;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("alt_all_pushed", i0 + i1, 12);
    n = 0;
    while (issued_cnt !== 16'd12 && n < 500) begin @(negedge clk); n++; end
    check("alt_issued", issued_cnt, 12);
    repeat (3) @(negedge clk);
    check("alt_queue_drained", exp_q.size(), 0);
    check("alt_idle", busy, 0);

    // single instruction, done in the third execute cycle
    done_delay = 3;
    exp_q.push_back(34'h3_1234_5678);
    req0_valid = 1'b1; req0_instr = 34'h3_1234_5678;
    #1 check("single_ready", req0_ready, 1);
    seq = '0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      seq = {seq[5:0], proc_instr_sig};
      if (j == 0) check("single_count", fifo_count, 1);
      if (j == 1) begin
        check("single_instr", proc_instr, 34'h3_1234_5678);
        check("single_arm_busy", busy, 1);
        check("single_arm_state", state_dbg, 1);
        check("single_popped", fifo_count, 0);
      end
      if (j == 4) check("single_hold", proc_instr, 34'h3_1234_5678);
    end
    check("single_sig_seq", seq, 7'b0011100);
    check("single_issued", issued_cnt, 13);
    check("single_len", last_len, 3);

    // done outside execute is ignored
    force_done = 1'b1;
    repeat (2) @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("stray_done_issued", issued_cnt, 13);
    check("stray_done_busy", busy, 0);

    // done coinciding with the last timer cycle: counted, no timeout
    done_delay = 31;
    exp_q.push_back(34'h0_0000_BEEF);
    req0_valid = 1'b1; req0_instr = 34'h0_0000_BEEF;
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (issued_cnt !== 16'd14 && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("edge_issued", issued_cnt, 14);
    check("edge_no_timeout", timeout_err, 0);
    check("edge_len", last_len, 31);

    // stalled processor: FIFO fills, then timeout frees a slot
    done_delay = 0;
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_instr = 34'h0_5000_0000 + IW'(acc);
      #1 r0 = req0_ready;
      @(posedge clk);
      if (r0) begin
        exp_q.push_back(34'h0_5000_0000 + IW'(acc));
        acc++;
      end
    end
    @(negedge clk);
    req1_valid = 1'b1;
    #1;
    check("stall_accepted", acc, 5);
    check("stall_count_full", fifo_count, 4);
    check("stall_ready0", req0_ready, 0);
    check("stall_ready1", req1_ready, 0);
    check("stall_sig", proc_instr_sig, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("stall_timeout", timeout_err, 1);
    check("stall_no_count", issued_cnt, 14);
    repeat (2) @(negedge clk);
    check("stall_len", last_len, 31);
    check("stall_slot_freed", fifo_count, 3);
    req1_valid = 1'b1; req1_instr = 34'h0_0000_0001;
    #1 check("stall_ready_again", req1_ready, 1);
    req1_valid = 1'b0;

    // reset in the middle of execute
    n = 0;
    while (proc_instr_sig !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("midrst_in_exec", state_dbg, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sig", proc_instr_sig, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_state", state_dbg, 0);
    check("midrst_busy", busy, 0);
    check("midrst_issued", issued_cnt, 0);
    check("midrst_timeout", timeout_err, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
